code_mem_loader: RTL and testbench
==================================

# code_mem_loader

Serial program loader that writes user code into the i281 instruction memory. It takes a byte stream (valid/ready) carrying a framed program image, assembles 17-bit instruction words and issues single-cycle write strobes to the 32-word code memory. Entries 0–15 are the low bank and entries 16–31 are the high bank. While a load is in progress it holds the CPU, then reports completion or a framing/checksum error.

## Interface
- No parameters. Fixed geometry: 32 words × 17 bits; start byte 8'hA5.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: a byte is offered on `rx_data`.
- `rx_data` in 8: byte stream.
- `rx_ready` out 1: loader accepts a byte this cycle. A byte transfers when `rx_valid && rx_ready`.
- `wr_en` out 1: one-cycle write strobe to code memory.
- `wr_addr` out 5: word address. Bit 4 = bank (0 low, 1 high); bits 3:0 = word within bank.
- `wr_data` out 17: instruction word.
- `cpu_hold` out 1: keeps the CPU from fetching.
- `load_done` out 1: last frame loaded and checksum matched. Sticky.
- `load_error` out 1: last frame failed. Sticky.

## Operation
- Frame format, in order:
  - `8'hA5`
  - N, the word count (1..32)
  - N × 3 word bytes: B0[0] = instr[16] (B0[7:1] ignored), B1 = instr[15:8], B2 = instr[7:0]
  - CK = 8-bit sum, mod 256, of all 3N word bytes
- Words are written to consecutive addresses 0..N-1. Word 16 is the first entry of the high bank.
- States:
  - IDLE: wait for a byte. `8'hA5` → COUNT; any other byte is discarded and the loader stays in IDLE.
  - COUNT: N == 0 or N > 32 → ERR. Otherwise latch N, clear address and sum → B0.
  - B0 → B1 → B2: each accepted byte is shifted into the word register and added to the sum.
  - B2: on acceptance → WRITE.
  - WRITE: for one cycle, `wr_en` = 1, `rx_ready` = 0, address increments. If address+1 == N → CSUM, else → B0.
  - CSUM: byte == sum → DONE, otherwise → ERR.
  - DONE, ERR: return to IDLE on the next cycle. The sticky flags remain.
- `cpu_hold` is 1 in every state except IDLE. It is also 0 in IDLE after ERR: the memory may be partially overwritten, and the system decides whether to run.
- Flags are cleared when a start byte is accepted in IDLE:
  - `load_done` is set on entry to DONE.
  - `load_error` is set on entry to ERR.
  - They are never set together.
- `rx_ready` is 1 in IDLE, COUNT, B0, B1, B2 and CSUM; it is 0 in WRITE, DONE and ERR.
- Width rules:
  - Address counter is 6 bits internally; it is compared against N (6 bits).
  - `wr_addr` = counter[4:0].
  - Sum is 8 bits and wraps.

## Timing
- Reset values: `rx_ready` = 0 while reset is asserted, then 1 in IDLE. `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `cpu_hold` = 0, `load_done` = 0, `load_error` = 0. State = IDLE.
- All outputs are registered or decoded from state only. No combinational path from `rx_valid` to any output.
- `wr_en` is asserted in the cycle after B2 is accepted, with `wr_addr`/`wr_data` stable in that same cycle.
- Minimum frame time is 3N + 3 accepted bytes plus N WRITE cycles plus 1 DONE/ERR cycle.
- `rx_valid` = 0 in any receive state stalls indefinitely. There is no timeout.
- `rx_valid` with `rx_ready` = 0: the byte is not consumed and the sender must hold it.
- If reset is asserted mid-frame: immediate return to IDLE and all outputs go to reset values. Words already written remain in memory.
- A start byte inside a frame has no special meaning; it is treated as data.

## Test plan
- Load N = 2: `A5 02 00 30 00 01 8B 08 CF`. Expect:
  - Two strobes: addr 0 data 17'h03000, then addr 1 data 17'h18B08.
  - CK = 00+30+00+01+8B+08 = C4. The frame sends CF → mismatch, so `load_error` = 1. Repeat with CK = C4 → `load_done` = 1.
- Full 32-word load with a ramp pattern (word i = i). Expect:
  - Strobes at addr 0..31 with bank bit set from addr 16.
  - Correct checksum → `load_done` = 1.
  - `cpu_hold` high from the COUNT cycle through DONE, low afterwards.
- Count errors: `A5 00` → ERR after 2 bytes. `A5 21` → ERR after 2 bytes. No `wr_en` in either case.
- Backpressure: a sender holding `rx_valid` continuously sees `rx_ready` = 0 exactly once per word, in the WRITE cycle. No byte is lost or duplicated.
- Garbage before start: `11 22 A5 01 01 FF FF FF` → the first two bytes are ignored. Expect a write of 17'h1FFFF at addr 0 and `load_done` = 1.
- Reset mid-frame: assert `rst_n` = 0 during B1 of word 3. Expect:
  - Outputs at reset values.
  - A following complete frame loads correctly.

Source files
------------

// File: rtl/code_mem_loader.sv
// Serial program loader for the i281 code memory.
// Framed byte stream in, 17-bit word write strobes out.
module code_mem_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [16:0] wr_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    localparam logic [7:0] START = 8'hA5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_COUNT,
        S_B0,
        S_B1,
        S_B2,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  n_q, n_d;
    logic [5:0]  addr_q, addr_d;
    logic [7:0]  sum_q, sum_d;
    logic [16:0] word_q, word_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        rdy_q, wen_q, hold_q;
    logic        acc;

    assign acc = rx_valid && rdy_q;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        word_d  = word_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (acc && rx_data == START) begin
                    state_d = S_COUNT;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_COUNT: begin
                if (acc) begin
                    if (rx_data == 8'd0 || rx_data > 8'd32) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        n_d     = rx_data[5:0];
                        addr_d  = 6'd0;
                        sum_d   = 8'd0;
                        state_d = S_B0;
                    end
                end
            end
            S_B0: begin
                if (acc) begin
                    word_d  = {16'd0, rx_data[0]};
                    sum_d   = sum_q + rx_data;
                    state_d = S_B1;
                end
            end
            S_B1: begin
                if (acc) begin
                    word_d  = {word_q[8:0], rx_data};
                    sum_d   = sum_q + rx_data;
                    state_d = S_B2;
                end
            end
            S_B2: begin
                if (acc) begin
                    word_d  = {word_q[8:0], rx_data};
                    sum_d   = sum_q + rx_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 6'd1;
                state_d = (addr_q + 6'd1 == n_q) ? S_CSUM : S_B0;
            end
            S_CSUM: begin
                if (acc) begin
                    if (rx_data == sum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and strobe flops track the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= 6'd0;
            addr_q  <= 6'd0;
            sum_q   <= 8'd0;
            word_q  <= 17'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            wen_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            word_q  <= word_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdy_q   <= (state_d == S_IDLE) || (state_d == S_COUNT) ||
                       (state_d == S_B0)   || (state_d == S_B1)    ||
                       (state_d == S_B2)   || (state_d == S_CSUM);
            wen_q   <= (state_d == S_WRITE);
            hold_q  <= (state_d != S_IDLE);
        end
    end

    assign rx_ready   = rdy_q;
    assign wr_en      = wen_q;
    assign wr_addr    = addr_q[4:0];
    assign wr_data    = word_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_error = err_q;

endmodule

// File: tb/tb_code_mem_loader.sv
// Randomized bench for code_mem_loader.
// A frame-level model predicts writes, flags and hold time.
module tb_code_mem_loader;

    typedef logic [7:0] bytes_t [$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [16:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    code_mem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int stalls  = 0;
    int hold_cnt = 0;
    logic [21:0] obs_wr [$];
    logic [21:0] exp_wr [$];
    int exp_res;
    int exp_hold;
    bytes_t frm;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) obs_wr.push_back({wr_addr, wr_data});
        if (cpu_hold) hold_cnt++;
    end

    // exp_res: 1 = load_done, 2 = load_error
    function automatic void model(input bytes_t q);
        int i, n, sum;
        logic [16:0] w;
        logic [4:0] a;
        exp_wr.delete();
        i = 0;
        while (i < q.size() && q[i] != 8'hA5) i++;
        i++;
        n = int'(q[i]);
        i++;
        if (n < 1 || n > 32) begin
            exp_res = 2;
            exp_hold = 2;
            return;
        end
        sum = 0;
        for (int k = 0; k < n; k++) begin
            w = {q[i][0], q[i+1], q[i+2]};
            sum += int'(q[i]) + int'(q[i+1]) + int'(q[i+2]);
            a = k[4:0];
            exp_wr.push_back({a, w});
            i += 3;
        end
        exp_res = (int'(q[i]) == sum % 256) ? 1 : 2;
        exp_hold = 4 * n + 3;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                @(negedge clk);
            end
        end
        rx_valid = 1'b1;
        rx_data = b;
        t = 0;
        while (!rx_ready && t < 100) begin
            stalls++;
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            check("rx_ready_timeout", 32'd0, 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input bytes_t q, input bit gaps,
                             input string name);
        int wb, hb, t, m;
        model(q);
        wb = obs_wr.size();
        hb = hold_cnt;
        stalls = 0;
        foreach (q[i]) send_byte(q[i], gaps);
        rx_valid = 1'b0;
        t = 0;
        while (cpu_hold && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({name, "_hold_release"}, {31'd0, cpu_hold}, 32'd0);
        @(negedge clk);
        m = obs_wr.size() - wb;
        check({name, "_nwrites"}, m, exp_wr.size());
        if (m > exp_wr.size()) m = exp_wr.size();
        for (int i = 0; i < m; i++)
            check({name, "_write"}, obs_wr[wb+i], exp_wr[i]);
        check({name, "_done"}, {31'd0, load_done}, {31'd0, exp_res == 1});
        check({name, "_error"}, {31'd0, load_error}, {31'd0, exp_res == 2});
        if (!gaps) begin
            check({name, "_stalls"}, stalls, exp_wr.size());
            check({name, "_hold_cycles"}, hold_cnt - hb, exp_hold);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({name, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        check({name, "_wr_addr"}, {27'd0, wr_addr}, 32'd0);
        check({name, "_wr_data"}, {15'd0, wr_data}, 32'd0);
        check({name, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({name, "_load_done"}, {31'd0, load_done}, 32'd0);
        check({name, "_load_error"}, {31'd0, load_error}, 32'd0);
    endtask

    task automatic build_random(input bit allow_bad);
        logic [16:0] w;
        logic [31:0] r;
        int n, sum;
        frm.delete();
        repeat ($urandom_range(0, 2)) begin
            r = $urandom;
            frm.push_back((r[7:0] == 8'hA5) ? 8'h5A : r[7:0]);
        end
        frm.push_back(8'hA5);
        if (allow_bad && $urandom_range(0, 5) == 0) begin
            n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 255);
            frm.push_back(n[7:0]);
            return;
        end
        n = $urandom_range(1, 32);
        frm.push_back(n[7:0]);
        sum = 0;
        for (int k = 0; k < n; k++) begin
            r = $urandom;
            w = r[16:0];
            r = $urandom;
            frm.push_back({r[7:1], w[16]});
            frm.push_back(w[15:8]);
            frm.push_back(w[7:0]);
            sum += int'({r[7:1], w[16]}) + int'(w[15:8]) + int'(w[7:0]);
        end
        if ($urandom_range(0, 2) == 0) sum += $urandom_range(1, 255);
        frm.push_back(8'(sum));
    endtask

    initial begin
        int wb;
        logic [7:0] r8;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

        wb = obs_wr.size();
        frm = '{8'hA5, 8'h02, 8'h00, 8'h30, 8'h00, 8'h01, 8'h8B, 8'h08, 8'hCF};
        run_frame(frm, 1'b0, "tp_bad_ck");
        check("tp_w0", obs_wr[wb], {5'd0, 17'h03000});
        check("tp_w1", obs_wr[wb+1], {5'd1, 17'h18B08});
        check("tp_bad_ck_err", {31'd0, load_error}, 32'd1);
        frm = '{8'hA5, 8'h02, 8'h00, 8'h30, 8'h00, 8'h01, 8'h8B, 8'h08, 8'hC4};
        run_frame(frm, 1'b0, "tp_good_ck");
        check("tp_good_ck_done", {31'd0, load_done}, 32'd1);

        frm.delete();
        frm.push_back(8'hA5);
        frm.push_back(8'd32);
        for (int i = 0; i < 32; i++) begin
            frm.push_back(8'h00);
            frm.push_back(8'h00);
            frm.push_back(8'(i));
        end
        frm.push_back(8'hF0);
        wb = obs_wr.size();
        run_frame(frm, 1'b0, "ramp32");
        check("ramp32_addr16_bank", {27'd0, obs_wr[wb+16][21:17]}, 32'd16);
        check("ramp32_done", {31'd0, load_done}, 32'd1);

        frm = '{8'hA5, 8'h00};
        run_frame(frm, 1'b0, "count_zero");
        frm = '{8'hA5, 8'h21};
        run_frame(frm, 1'b0, "count_33");

        frm = '{8'h11, 8'h22, 8'hA5, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'hFF};
        wb = obs_wr.size();
        run_frame(frm, 1'b0, "garbage");
        check("garbage_w0", obs_wr[wb], {5'd0, 17'h1FFFF});

        wb = obs_wr.size();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h05, 1'b0);
        repeat (7) begin
            r8 = 8'($urandom);
            send_byte(r8, 1'b0);
        end
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        check("midreset_nwrites", obs_wr.size() - wb, 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        build_random(1'b0);
        run_frame(frm, 1'b0, "after_reset");

        for (int i = 0; i < 14; i++) begin
            build_random(1'b1);
            run_frame(frm, i[0], "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
